// File: rtl/stab_sweep_ctrl_if.sv
// rtl/stab_sweep_ctrl_if.sv - stimulus and measurement handshake between sweep controller and analyser front end
interface stab_sweep_ctrl_if #(
  parameter int FW = 16,
  parameter int MW = 24
);
  logic [FW-1:0] freq_code;
  logic          stim_en;
  logic          meas_req;
  logic          meas_ack;
  logic [MW-1:0] in_mag;
  logic [MW-1:0] out_mag;

  modport master (
    output freq_code, stim_en, meas_req,
    input  meas_ack, in_mag, out_mag
  );

  modport slave (
    input  freq_code, stim_en, meas_req,
    output meas_ack, in_mag, out_mag
  );
endinterface

// File: rtl/stab_sweep_ctrl.sv
// rtl/stab_sweep_ctrl.sv - loop-gain sweep sequencer: steps frequency, settles, measures, flags unity crossover
module stab_sweep_ctrl #(
  parameter int FW      = 16,
  parameter int MW      = 24,
  parameter int F_START = 100,
  parameter int F_STOP  = 1000,
  parameter int F_STEP  = 100,
  parameter int SETTLE  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              xover_found,
  output logic [FW-1:0]     xover_code,
  output logic [15:0]       point_cnt,
  stab_sweep_ctrl_if.master meas
);

  localparam int            CW        = $clog2(SETTLE + 1);
  localparam logic [CW-1:0] LP_SETTLE = CW'(SETTLE);
  localparam logic [FW-1:0] LP_START  = FW'(F_START);
  localparam logic [FW:0]   LP_STEP   = (FW+1)'(F_STEP);
  localparam logic [FW:0]   LP_STOP   = (FW+1)'(F_STOP);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_MEASURE,
    S_EVAL,
    S_DONE
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_settle;
  logic [FW-1:0] r_freq;
  logic          r_stim_en;
  logic          r_busy;
  logic          r_prev_ge;
  logic          r_xover_found;
  logic [FW-1:0] r_xover_code;
  logic [15:0]   r_point_cnt;
  logic [MW-1:0] r_in_cap;
  logic [MW-1:0] r_out_cap;

  logic          w_ge;
  logic [FW:0]   w_sum;
  logic          w_has_next;
  logic          w_meas_req;
  logic          w_done;

  // Sum is one bit wider so a step past the top of the code range reads as "no next point".
  assign w_ge       = (r_out_cap >= r_in_cap);
  assign w_sum      = {1'b0, r_freq} + LP_STEP;
  assign w_has_next = (w_sum <= LP_STOP);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_meas_req  = 1'b0;
    w_done      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) w_state_nxt = S_SETTLE;
      end
      S_SETTLE: begin
        if (r_settle == CW'(1)) w_state_nxt = S_MEASURE;
      end
      S_MEASURE: begin
        w_meas_req = 1'b1;
        if (meas.meas_ack) w_state_nxt = S_EVAL;
      end
      S_EVAL: begin
        w_state_nxt = w_has_next ? S_SETTLE : S_DONE;
      end
      S_DONE: begin
        w_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_settle      <= '0;
      r_freq        <= '0;
      r_stim_en     <= 1'b0;
      r_busy        <= 1'b0;
      r_prev_ge     <= 1'b0;
      r_xover_found <= 1'b0;
      r_xover_code  <= '0;
      r_point_cnt   <= '0;
      r_in_cap      <= '0;
      r_out_cap     <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_freq        <= LP_START;
            r_stim_en     <= 1'b1;
            r_busy        <= 1'b1;
            r_settle      <= LP_SETTLE;
            r_xover_found <= 1'b0;
            r_xover_code  <= '0;
            r_point_cnt   <= '0;
            r_prev_ge     <= 1'b0;
          end
        end
        S_SETTLE: begin
          r_settle <= r_settle - CW'(1);
        end
        S_MEASURE: begin
          if (meas.meas_ack) begin
            r_in_cap    <= meas.in_mag;
            r_out_cap   <= meas.out_mag;
            r_point_cnt <= r_point_cnt + 16'd1;
          end
        end
        S_EVAL: begin
          // Only the first falling transition through unity gain is reported.
          if (r_prev_ge && !w_ge && !r_xover_found) begin
            r_xover_found <= 1'b1;
            r_xover_code  <= r_freq;
          end
          r_prev_ge <= w_ge;
          if (w_has_next) begin
            r_freq   <= w_sum[FW-1:0];
            r_settle <= LP_SETTLE;
          end
        end
        S_DONE: begin
          r_stim_en <= 1'b0;
          r_busy    <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign busy          = r_busy;
  assign done          = w_done;
  assign xover_found   = r_xover_found;
  assign xover_code    = r_xover_code;
  assign point_cnt     = r_point_cnt;
  assign meas.freq_code = r_freq;
  assign meas.stim_en   = r_stim_en;
  assign meas.meas_req  = w_meas_req;

endmodule

// File: tb/tb_stab_sweep_ctrl.sv
// tb/tb_stab_sweep_ctrl.sv - directed self-checking bench for stab_sweep_ctrl
module tb_stab_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        busy, done, xover_found;
  logic [15:0] xover_code, point_cnt;

  logic        start2 = 1'b0;
  logic        busy2, done2, xover_found2;
  logic [15:0] xover_code2, point_cnt2;

  int n_checks = 0;
  int n_fail   = 0;

  stab_sweep_ctrl_if #(.FW(16), .MW(24)) mif ();
  stab_sweep_ctrl_if #(.FW(16), .MW(24)) mif2 ();

  stab_sweep_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .xover_found(xover_found), .xover_code(xover_code), .point_cnt(point_cnt),
    .meas(mif)
  );

  stab_sweep_ctrl #(.F_START(60000), .F_STOP(65535), .F_STEP(10000), .SETTLE(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .busy(busy2), .done(done2),
    .xover_found(xover_found2), .xover_code(xover_code2), .point_cnt(point_cnt2),
    .meas(mif2)
  );

  always #5 clk = ~clk;

  int in_tab[10]  = '{0, 1000, 1000, 500, 1000, 1000, 100, 200, 5, 1};
  int out_tab[10] = '{0, 1500, 1000, 900,  999,   10, 200, 100, 5, 0};

  int codes_seen[$];
  int req_hi[$];

  task automatic run_sweep(input int mode, input int delay_code, input int spur_code,
                           input int rst_code, input bit spam,
                           output int done_cnt, output int done_cyc,
                           output int spur_before, output int spur_after,
                           output bit busy_after, output bit stim_after, output bit timed_out);
    int  wait_n = 0;
    int  hi = 0;
    int  idx;
    bit  spur_pending = 0;
    bit  spur_done = 0;
    bit  finished = 0;
    codes_seen.delete();
    req_hi.delete();
    done_cnt = 0; done_cyc = -1; spur_before = -1; spur_after = -1;
    busy_after = 1'b1; stim_after = 1'b1; timed_out = 1'b1;
    @(negedge clk);
    start = 1'b1;
    for (int cyc = 1; cyc <= 3000; cyc++) begin
      @(negedge clk);
      mif.meas_ack = 1'b0;
      start = (spam && !finished && !done && (cyc % 5 == 0));
      if (spur_pending) begin
        spur_after = int'(point_cnt);
        spur_pending = 0;
      end
      if (finished) begin
        if (done) done_cnt++;
        busy_after = busy;
        stim_after = mif.stim_en;
        timed_out = 1'b0;
        break;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        finished = 1;
      end
      if (rst_code > 0 && mif.meas_req && int'(mif.freq_code) == rst_code) begin
        rst_n = 1'b0;
        @(negedge clk);
        timed_out = 1'b0;
        return;
      end
      if (mif.meas_req) begin
        hi++;
        if (wait_n >= ((int'(mif.freq_code) == delay_code) ? 7 : 0)) begin
          idx = (int'(mif.freq_code) - 100) / 100;
          mif.in_mag  = (mode == 0) ? 24'd1000 : 24'(in_tab[idx]);
          mif.out_mag = (mode == 0) ? 24'd2000 : 24'(out_tab[idx]);
          mif.meas_ack = 1'b1;
          codes_seen.push_back(int'(mif.freq_code));
          req_hi.push_back(hi);
          hi = 0;
          wait_n = 0;
        end else begin
          wait_n++;
        end
      end else if (!spur_done && spur_code > 0 && busy && int'(mif.freq_code) == spur_code) begin
        mif.meas_ack = 1'b1;
        spur_before = int'(point_cnt);
        spur_pending = 1;
        spur_done = 1;
      end
    end
    mif.meas_ack = 1'b0;
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
    n_checks++; if (mif.freq_code !== 16'd0) begin n_fail++; $display("FAIL reset_freq got %0d want 0", mif.freq_code); end
    n_checks++; if (mif.stim_en !== 1'b0) begin n_fail++; $display("FAIL reset_stim got %b want 0", mif.stim_en); end
    n_checks++; if (mif.meas_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got %b want 0", mif.meas_req); end
    n_checks++; if ({xover_found, xover_code, point_cnt} !== 33'd0) begin n_fail++; $display("FAIL reset_xover got %b/%0d/%0d want 0/0/0", xover_found, xover_code, point_cnt); end
    rst_n = 1'b1;
  endtask

  task automatic test_no_xover();
    int dc, dcy, sb, sa; bit ba, sta, to;
    run_sweep(0, 0, 0, 0, 1'b1, dc, dcy, sb, sa, ba, sta, to);
    n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL nox_timeout got %b want 0", to); end
    n_checks++; if (codes_seen.size() != 10) begin n_fail++; $display("FAIL nox_points got %0d want 10", codes_seen.size()); end
    for (int i = 0; i < codes_seen.size() && i < 10; i++) begin
      n_checks++; if (codes_seen[i] != 100 + 100 * i) begin n_fail++; $display("FAIL nox_code[%0d] got %0d want %0d", i, codes_seen[i], 100 + 100 * i); end
    end
    if (req_hi.size() > 0) begin
      n_checks++; if (req_hi[0] != 1) begin n_fail++; $display("FAIL nox_req_len got %0d want 1", req_hi[0]); end
    end
    n_checks++; if (point_cnt !== 16'd10) begin n_fail++; $display("FAIL nox_point_cnt got %0d want 10", point_cnt); end
    n_checks++; if (xover_found !== 1'b0) begin n_fail++; $display("FAIL nox_found got %b want 0", xover_found); end
    n_checks++; if (dc != 1) begin n_fail++; $display("FAIL nox_done_cnt got %0d want 1", dc); end
    n_checks++; if (dcy != 341) begin n_fail++; $display("FAIL nox_done_cycle got %0d want 341", dcy); end
    n_checks++; if (ba !== 1'b0 || sta !== 1'b0) begin n_fail++; $display("FAIL nox_busy_stim_after got %b/%b want 0/0", ba, sta); end
    n_checks++; if (mif.freq_code !== 16'd1000) begin n_fail++; $display("FAIL nox_freq_hold got %0d want 1000", mif.freq_code); end
  endtask

  task automatic test_xover();
    int dc, dcy, sb, sa; bit ba, sta, to;
    run_sweep(1, 0, 0, 0, 1'b0, dc, dcy, sb, sa, ba, sta, to);
    n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL xo_timeout got %b want 0", to); end
    n_checks++; if (xover_found !== 1'b1) begin n_fail++; $display("FAIL xo_found got %b want 1", xover_found); end
    n_checks++; if (xover_code !== 16'd500) begin n_fail++; $display("FAIL xo_code got %0d want 500", xover_code); end
    n_checks++; if (point_cnt !== 16'd10) begin n_fail++; $display("FAIL xo_point_cnt got %0d want 10", point_cnt); end
    n_checks++; if (dc != 1) begin n_fail++; $display("FAIL xo_done_cnt got %0d want 1", dc); end
  endtask

  task automatic test_ack_delay();
    int dc, dcy, sb, sa; bit ba, sta, to;
    run_sweep(0, 300, 200, 0, 1'b0, dc, dcy, sb, sa, ba, sta, to);
    n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL dly_timeout got %b want 0", to); end
    n_checks++; if (req_hi.size() < 3 || req_hi[2] != 8) begin n_fail++; $display("FAIL dly_req_len got %0d want 8", (req_hi.size() < 3) ? -1 : req_hi[2]); end
    n_checks++; if (sb != 1 || sa != 1) begin n_fail++; $display("FAIL dly_spur_ack got %0d->%0d want 1->1", sb, sa); end
    n_checks++; if (point_cnt !== 16'd10) begin n_fail++; $display("FAIL dly_point_cnt got %0d want 10", point_cnt); end
    n_checks++; if (dcy != 348) begin n_fail++; $display("FAIL dly_done_cycle got %0d want 348", dcy); end
  endtask

  task automatic test_mid_reset();
    int dc, dcy, sb, sa; bit ba, sta, to;
    // The previous sweep found a crossover; it must still be held while idle.
    n_checks++; if (xover_found !== 1'b1 || xover_code !== 16'd500) begin n_fail++; $display("FAIL hold_xover got %b/%0d want 1/500", xover_found, xover_code); end
    run_sweep(1, 0, 0, 400, 1'b0, dc, dcy, sb, sa, ba, sta, to);
    n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL mrst_timeout got %b want 0", to); end
    n_checks++; if ({busy, done, mif.stim_en, mif.meas_req} !== 4'b0000) begin n_fail++; $display("FAIL mrst_ctrl got %b want 0000", {busy, done, mif.stim_en, mif.meas_req}); end
    n_checks++; if (mif.freq_code !== 16'd0 || point_cnt !== 16'd0) begin n_fail++; $display("FAIL mrst_regs got %0d/%0d want 0/0", mif.freq_code, point_cnt); end
    rst_n = 1'b1;
    run_sweep(1, 0, 0, 0, 1'b0, dc, dcy, sb, sa, ba, sta, to);
    n_checks++; if (codes_seen.size() < 1 || codes_seen[0] != 100) begin n_fail++; $display("FAIL mrst_restart_code got %0d want 100", (codes_seen.size() < 1) ? -1 : codes_seen[0]); end
    n_checks++; if (xover_code !== 16'd500 || point_cnt !== 16'd10) begin n_fail++; $display("FAIL mrst_resweep got %0d/%0d want 500/10", xover_code, point_cnt); end
  endtask

  task automatic test_overflow();
    int acks = 0;
    int dcnt = 0;
    int dcy = -1;
    bit fin = 0;
    mif2.in_mag = 24'd10;
    mif2.out_mag = 24'd20;
    @(negedge clk);
    start2 = 1'b1;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      @(negedge clk);
      start2 = 1'b0;
      mif2.meas_ack = 1'b0;
      if (fin) begin
        if (done2) dcnt++;
        break;
      end
      if (done2) begin dcnt++; dcy = cyc; fin = 1; end
      if (mif2.meas_req) begin mif2.meas_ack = 1'b1; acks++; end
    end
    n_checks++; if (acks != 1) begin n_fail++; $display("FAIL ovf_acks got %0d want 1", acks); end
    n_checks++; if (point_cnt2 !== 16'd1) begin n_fail++; $display("FAIL ovf_point_cnt got %0d want 1", point_cnt2); end
    n_checks++; if (mif2.freq_code !== 16'd60000) begin n_fail++; $display("FAIL ovf_freq got %0d want 60000", mif2.freq_code); end
    n_checks++; if (dcnt != 1 || dcy != 7) begin n_fail++; $display("FAIL ovf_done got cnt %0d cyc %0d want 1/7", dcnt, dcy); end
    n_checks++; if (busy2 !== 1'b0 || xover_found2 !== 1'b0) begin n_fail++; $display("FAIL ovf_busy_xover got %b/%b want 0/0", busy2, xover_found2); end
  endtask

  initial begin
    mif.meas_ack = 1'b0; mif.in_mag = '0; mif.out_mag = '0;
    mif2.meas_ack = 1'b0; mif2.in_mag = '0; mif2.out_mag = '0;
    test_reset();
    test_no_xover();
    test_xover();
    test_mid_reset();
    test_ack_delay();
    test_overflow();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
